seq_stage_controller: RTL

Multi-cycle sequencer for the Y86-64 SEQ datapath (fetch, decode/register block, execute block, memory, PC update). It steps one stage per clock, skips the memory stage for non-memory instructions and handshakes with data memory. It gates register-file write-back and PC update, and maintains the architectural status code. It sits above the processor datapath and replaces the ad-hoc per-icode sequencing with one explicit FSM.

---
 rtl/y86_pkg.sv | 44 ++++
 rtl/seq_instr_class.sv | 47 ++++
 rtl/seq_stage_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, sequencer states
// and the instruction-class bundle produced by the decoder.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_FETCH     = 3'd1;
  localparam state_t ST_DECODE    = 3'd2;
  localparam state_t ST_EXECUTE   = 3'd3;
  localparam state_t ST_MEMORY    = 3'd4;
  localparam state_t ST_WRITEBACK = 3'd5;
  localparam state_t ST_PCUPD     = 3'd6;
  localparam state_t ST_HALT      = 3'd7;

  typedef struct packed {
    logic valid;
    logic needs_mem;
    logic mem_write;
    logic wb_e;
    logic wb_m;
  } instr_class_t;

endpackage

// File: rtl/seq_instr_class.sv
// Combinational instruction classifier: maps icode/ifun (and the condition
// flag for conditional moves) to the sequencing attributes the FSM needs.
module seq_instr_class
  import y86_pkg::*;
(
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic         cnd,
  output instr_class_t cls
);

  always_comb begin
    cls       = '0;
    cls.valid = (icode <= I_POPQ);
    case (icode)
      // ifun 0 is an unconditional rrmovq; any other ifun is a cmovXX
      I_RRMOVQ: cls.wb_e = (ifun == 4'h0) || cnd;
      I_IRMOVQ,
      I_OPQ: cls.wb_e = 1'b1;
      I_RMMOVQ: begin
        cls.needs_mem = 1'b1;
        cls.mem_write = 1'b1;
      end
      I_MRMOVQ: begin
        cls.needs_mem = 1'b1;
        cls.wb_m      = 1'b1;
      end
      I_CALL,
      I_PUSHQ: begin
        cls.needs_mem = 1'b1;
        cls.mem_write = 1'b1;
        cls.wb_e      = 1'b1;
      end
      I_RET: begin
        cls.needs_mem = 1'b1;
        cls.wb_e      = 1'b1;
      end
      I_POPQ: begin
        cls.needs_mem = 1'b1;
        cls.wb_e      = 1'b1;
        cls.wb_m      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_stage_controller.sv
// Stage sequencer for the Y86-64 SEQ datapath: one stage per clock, memory
// handshake with timeout, write-back/PC gating and architectural status.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | after reset, waiting for start
// FETCH     | instruction fetch; icode/ifun and fetch errors sampled
// DECODE    | register read
// EXECUTE   | ALU/CC; cnd sampled, memory stage skipped when not needed
// MEMORY    | data memory request held until ack or timeout
// WRITEBACK | register-file write of valE and/or valM
// PCUPD     | PC latch, retired-instruction count
// HALT      | stopped on halt or error; stat holds the cause
module seq_stage_controller
  import y86_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic             imem_error,
  input  logic             func_error,
  input  logic             cnd,
  input  logic             dmem_ack,
  input  logic             dmem_error,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             mem_req,
  output logic             mem_write,
  output logic             wb_en_e,
  output logic             wb_en_m,
  output logic             pc_en,
  output logic [2:0]       stat,
  output logic             running,
  output logic [CNT_W-1:0] instr_count
);

  localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           next_state;
  logic [2:0]       next_stat;
  logic [3:0]       icode_q;
  logic [3:0]       ifun_q;
  logic             cnd_q;
  logic [TMR_W-1:0] tmr;
  logic             tmr_tc;

  logic [3:0]       cls_icode;
  logic [3:0]       cls_ifun;
  logic             cls_cnd;
  instr_class_t     cls;

  // Classify the live fetch bus during FETCH and the live cnd during EXECUTE,
  // so the registered outputs for the following state are already correct.
  assign cls_icode = (state == ST_FETCH)   ? icode : icode_q;
  assign cls_ifun  = (state == ST_FETCH)   ? ifun  : ifun_q;
  assign cls_cnd   = (state == ST_EXECUTE) ? cnd   : cnd_q;

  seq_instr_class u_instr_class (
    .icode (cls_icode),
    .ifun  (cls_ifun),
    .cnd   (cls_cnd),
    .cls   (cls)
  );

  assign tmr_tc = (tmr == '0);

  always_comb begin
    next_state = state;
    next_stat  = stat;
    case (state)
      ST_IDLE,
      ST_HALT: begin
        if (start) begin
          next_state = ST_FETCH;
          next_stat  = STAT_AOK;
        end
      end
      ST_FETCH: begin
        if (imem_error) begin
          next_state = ST_HALT;
          next_stat  = STAT_ADR;
        end else if (!cls.valid || func_error) begin
          next_state = ST_HALT;
          next_stat  = STAT_INS;
        end else if (icode == I_HALT) begin
          next_state = ST_HALT;
          next_stat  = STAT_HLT;
        end else begin
          next_state = ST_DECODE;
        end
      end
      ST_DECODE:  next_state = ST_EXECUTE;
      ST_EXECUTE: next_state = cls.needs_mem ? ST_MEMORY : ST_WRITEBACK;
      ST_MEMORY: begin
        if (dmem_ack) begin
          if (dmem_error) begin
            next_state = ST_HALT;
            next_stat  = STAT_ADR;
          end else begin
            next_state = ST_WRITEBACK;
          end
        end else if (tmr_tc) begin
          next_state = ST_HALT;
          next_stat  = STAT_ADR;
        end
      end
      ST_WRITEBACK: next_state = ST_PCUPD;
      ST_PCUPD:     next_state = ST_FETCH;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      stat        <= STAT_AOK;
      icode_q     <= '0;
      ifun_q      <= '0;
      cnd_q       <= 1'b0;
      tmr         <= '0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      stat  <= next_stat;
      if (state == ST_FETCH) begin
        icode_q <= icode;
        ifun_q  <= ifun;
      end
      if (state == ST_EXECUTE) cnd_q <= cnd;
      // Down-counter: loaded on MEMORY entry, terminal count ends the wait
      if (next_state == ST_MEMORY && state != ST_MEMORY) tmr <= TMR_LOAD;
      else if (state == ST_MEMORY && !tmr_tc)            tmr <= tmr - TMR_W'(1);
      if (state == ST_PCUPD) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_en   <= 1'b0;
      decode_en  <= 1'b0;
      execute_en <= 1'b0;
      mem_req    <= 1'b0;
      mem_write  <= 1'b0;
      wb_en_e    <= 1'b0;
      wb_en_m    <= 1'b0;
      pc_en      <= 1'b0;
      running    <= 1'b0;
    end else begin
      fetch_en   <= (next_state == ST_FETCH);
      decode_en  <= (next_state == ST_DECODE);
      execute_en <= (next_state == ST_EXECUTE);
      mem_req    <= (next_state == ST_MEMORY);
      mem_write  <= (next_state == ST_MEMORY) && cls.mem_write;
      wb_en_e    <= (next_state == ST_WRITEBACK) && cls.wb_e;
      wb_en_m    <= (next_state == ST_WRITEBACK) && cls.wb_m;
      pc_en      <= (next_state == ST_PCUPD);
      running    <= (next_state != ST_IDLE) && (next_state != ST_HALT);
    end
  end

endmodule
